// File: rtl/ram_boot_loader.sv
// ram_boot_loader: byte-stream image loader for the CPU external RAM-load port.
// The stream is a 16-bit word-count header followed by big-endian 32-bit words.
// Each word is written to BASE_ADDR + index. The CPU is held out of run until
// the whole image has been loaded.
module ram_boot_loader #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic [ADDR_W-1:0] ld_ram_addr,
    output logic [31:0]       ld_ram_wdata,
    output logic              ld_ram_wen,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Largest image that fits between BASE_ADDR and the top of the address space
    localparam logic [32:0] CAP  = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
    localparam logic [31:0] TMAX = 32'(TIMEOUT) - 32'd1;

    state_t              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [31:0]         timer_q, timer_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                xfer;
    logic                timeout_hit;
    logic [15:0]         cnt_new;

    assign in_ready    = (state_q == S_IDLE) || (state_q == S_HDR_LO) || (state_q == S_DATA);
    assign xfer        = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT != 0) && !xfer && (timer_q == TMAX);
    assign cnt_new     = {cnt_hi_q, in_data};

    // Status outputs are pure decodes of the registered state
    assign ld_ram_wen   = (state_q == S_WRITE);
    assign ld_ram_addr  = addr_q;
    assign ld_ram_wdata = wdata_q;
    assign cpu_run      = (state_q == S_DONE);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR);
    assign busy         = (state_q == S_HDR_LO) || (state_q == S_DATA) || (state_q == S_WRITE);

    // State and datapath registers; reset aborts any load in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_hi_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            timer_q  <= '0;
            asm_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            timer_q  <= timer_d;
            asm_q    <= asm_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state, header/word assembly and inter-byte timeout
    always_comb begin
        state_d  = state_q;
        cnt_hi_d = cnt_hi_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        timer_d  = timer_q;
        asm_d    = asm_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (xfer) begin
                    cnt_hi_d = in_data;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    timer_d = '0;
                    cnt_d   = cnt_new;
                    if (cnt_new == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({17'd0, cnt_new} > CAP) begin
                        state_d = S_ERR;
                    end else begin
                        idx_d   = '0;
                        bcnt_d  = '0;
                        state_d = S_DATA;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    timer_d = '0;
                    if (bcnt_q == 2'd3) begin
                        wdata_d = {asm_q, in_data};
                        addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                        bcnt_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        asm_d  = {asm_q[15:0], in_data};
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_WRITE: begin
                timer_d = '0;
                idx_d   = idx_q + 16'd1;
                if (idx_q + 16'd1 == cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    idx_d   = '0;
                    bcnt_d  = '0;
                    timer_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
